// File: rtl/mips_pipe_core_fwd.sv
// mips_pipe_core_fwd: 5-stage MIPS integer pipeline (IF/ID/EX/MEM/WB)
// with EX forwarding, load-use interlock and branch/jump flush.
module mips_pipe_core_fwd #(
    parameter int unsigned FWD_EN        = 1,
    parameter logic [31:0] PC_RESET      = 32'h0000_0000,
    parameter int unsigned BR_RESOLVE_EX = 1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic        dmem_we,
    output logic        dmem_re,
    input  logic [31:0] dmem_rdata,
    output logic        retire_valid,
    output logic [31:0] retire_pc,
    output logic        stall
);

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
    } alu_e;

    logic [31:0] r_pc;
    logic        r_ifid_valid;
    logic [31:0] r_ifid_pc, r_ifid_instr;

    logic        r_idex_valid, r_idex_rw, r_idex_mr, r_idex_mw;
    logic        r_idex_br, r_idex_isrc;
    alu_e        r_idex_aop;
    logic [4:0]  r_idex_rs, r_idex_rt, r_idex_dst;
    logic [31:0] r_idex_pc, r_idex_rsv, r_idex_rtv, r_idex_imm;

    logic        r_exmem_valid, r_exmem_rw, r_exmem_mr, r_exmem_mw;
    logic        r_exmem_take;
    logic [4:0]  r_exmem_dst;
    logic [31:0] r_exmem_pc, r_exmem_alu, r_exmem_sd, r_exmem_tgt;

    logic        r_memwb_valid, r_memwb_rw;
    logic [4:0]  r_memwb_dst;
    logic [31:0] r_memwb_pc, r_memwb_res;

    logic [31:0] r_rf [32];

    logic [5:0]  w_opc, w_fn;
    logic [4:0]  w_rs, w_rt, w_rd, w_dst;
    logic [31:0] w_imm, w_jt, w_rsv, w_rtv;
    logic        w_rw, w_mr, w_mw, w_br, w_jmp, w_isrc;
    logic        w_urs, w_urt;
    alu_e        w_aop;

    logic        w_wb_we, w_ex_rd, w_mem_rd;
    logic        w_ex_dep, w_mem_dep, w_stall_req, w_stall;
    logic        w_flush, w_ex_take;
    logic        w_exm_a, w_exm_b, w_mwb_a, w_mwb_b;
    logic [31:0] w_fa, w_fb, w_alu_b, w_alu, w_ex_tgt, w_br_tgt;

    function automatic logic f_hit(
        input logic       v,
        input logic [4:0] d,
        input logic [4:0] s,
        input logic       u
    );
        return v && (d != 5'd0) && (d == s) && u;
    endfunction

    assign w_opc = r_ifid_instr[31:26];
    assign w_rs  = r_ifid_instr[25:21];
    assign w_rt  = r_ifid_instr[20:16];
    assign w_rd  = r_ifid_instr[15:11];
    assign w_fn  = r_ifid_instr[5:0];
    assign w_imm = {{16{r_ifid_instr[15]}}, r_ifid_instr[15:0]};
    assign w_jt  = ((r_ifid_pc + 32'd4) & 32'hF000_0000)
                 | {4'b0, r_ifid_instr[25:0], 2'b00};

    // Decode the IF/ID instruction; unsupported encodings become NOPs.
    always_comb begin
        w_rw = 1'b0; w_mr = 1'b0; w_mw = 1'b0;
        w_br = 1'b0; w_jmp = 1'b0; w_isrc = 1'b0;
        w_urs = 1'b0; w_urt = 1'b0;
        w_aop = ALU_ADD; w_dst = 5'd0;
        if (r_ifid_valid) begin
            case (w_opc)
                6'b000000: begin
                    w_dst = w_rd; w_rw = 1'b1;
                    w_urs = 1'b1; w_urt = 1'b1;
                    case (w_fn)
                        6'b100000: w_aop = ALU_ADD;
                        6'b100010: w_aop = ALU_SUB;
                        6'b100100: w_aop = ALU_AND;
                        6'b100101: w_aop = ALU_OR;
                        6'b101010: w_aop = ALU_SLT;
                        default: begin
                            w_rw = 1'b0; w_urs = 1'b0; w_urt = 1'b0;
                        end
                    endcase
                end
                6'b100011: begin
                    w_rw = 1'b1; w_mr = 1'b1; w_isrc = 1'b1;
                    w_dst = w_rt; w_urs = 1'b1;
                end
                6'b101011: begin
                    w_mw = 1'b1; w_isrc = 1'b1;
                    w_urs = 1'b1; w_urt = 1'b1;
                end
                6'b000100: begin
                    w_br = 1'b1; w_urs = 1'b1; w_urt = 1'b1;
                end
                6'b001000: begin
                    w_rw = 1'b1; w_isrc = 1'b1;
                    w_dst = w_rt; w_urs = 1'b1;
                end
                6'b000010: w_jmp = 1'b1;
                default: ;
            endcase
        end
    end

    // WB writes in the first half-cycle, so ID sees it via bypass.
    assign w_wb_we = r_memwb_valid && r_memwb_rw && (r_memwb_dst != 5'd0);
    assign w_rsv = (w_wb_we && r_memwb_dst == w_rs) ? r_memwb_res : r_rf[w_rs];
    assign w_rtv = (w_wb_we && r_memwb_dst == w_rt) ? r_memwb_res : r_rf[w_rt];

    assign w_ex_rd   = r_idex_valid && r_idex_rw;
    assign w_mem_rd  = r_exmem_valid && r_exmem_rw;
    assign w_ex_dep  = f_hit(w_ex_rd, r_idex_dst, w_rs, w_urs)
                    || f_hit(w_ex_rd, r_idex_dst, w_rt, w_urt);
    assign w_mem_dep = f_hit(w_mem_rd, r_exmem_dst, w_rs, w_urs)
                    || f_hit(w_mem_rd, r_exmem_dst, w_rt, w_urt);
    assign w_stall_req = (FWD_EN != 0) ? (w_ex_dep && r_idex_mr)
                                       : (w_ex_dep || w_mem_dep);
    assign w_stall = w_stall_req && !w_flush;

    assign w_exm_a = (FWD_EN != 0) && w_mem_rd && !r_exmem_mr
                  && (r_exmem_dst != 5'd0) && (r_exmem_dst == r_idex_rs);
    assign w_exm_b = (FWD_EN != 0) && w_mem_rd && !r_exmem_mr
                  && (r_exmem_dst != 5'd0) && (r_exmem_dst == r_idex_rt);
    assign w_mwb_a = (FWD_EN != 0) && w_wb_we && (r_memwb_dst == r_idex_rs);
    assign w_mwb_b = (FWD_EN != 0) && w_wb_we && (r_memwb_dst == r_idex_rt);
    assign w_fa = w_exm_a ? r_exmem_alu : (w_mwb_a ? r_memwb_res : r_idex_rsv);
    assign w_fb = w_exm_b ? r_exmem_alu : (w_mwb_b ? r_memwb_res : r_idex_rtv);
    assign w_alu_b = r_idex_isrc ? r_idex_imm : w_fb;

    // EX-stage ALU.
    always_comb begin
        w_alu = w_fa + w_alu_b;
        case (r_idex_aop)
            ALU_SUB: w_alu = w_fa - w_alu_b;
            ALU_AND: w_alu = w_fa & w_alu_b;
            ALU_OR:  w_alu = w_fa | w_alu_b;
            ALU_SLT: w_alu = {31'd0, $signed(w_fa) < $signed(w_alu_b)};
            default: w_alu = w_fa + w_alu_b;
        endcase
    end

    assign w_ex_take = r_idex_valid && r_idex_br && (w_fa == w_fb);
    assign w_ex_tgt  = r_idex_pc + 32'd4 + (r_idex_imm << 2);
    assign w_flush   = (BR_RESOLVE_EX != 0) ? w_ex_take : r_exmem_take;
    assign w_br_tgt  = (BR_RESOLVE_EX != 0) ? w_ex_tgt : r_exmem_tgt;

    // PC and IF/ID: branch redirect beats stall, stall beats jump.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc         <= PC_RESET;
            r_ifid_valid <= 1'b0;
            r_ifid_pc    <= '0;
            r_ifid_instr <= '0;
        end else if (w_flush) begin
            r_pc         <= w_br_tgt;
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= '0;
        end else if (!w_stall) begin
            if (w_jmp) begin
                r_pc         <= w_jt;
                r_ifid_valid <= 1'b0;
                r_ifid_instr <= '0;
            end else begin
                r_pc         <= r_pc + 32'd4;
                r_ifid_valid <= 1'b1;
                r_ifid_pc    <= r_pc;
                r_ifid_instr <= imem_rdata;
            end
        end
    end

    // ID/EX: a bubble on reset, flush or stall.
    always_ff @(posedge clk) begin
        if (reset || w_flush || w_stall) begin
            r_idex_valid <= 1'b0; r_idex_rw <= 1'b0;
            r_idex_mr <= 1'b0; r_idex_mw <= 1'b0;
            r_idex_br <= 1'b0; r_idex_isrc <= 1'b0;
            r_idex_aop <= ALU_ADD; r_idex_dst <= 5'd0;
            r_idex_rs <= 5'd0; r_idex_rt <= 5'd0;
            r_idex_pc <= '0; r_idex_imm <= '0;
            r_idex_rsv <= '0; r_idex_rtv <= '0;
        end else begin
            r_idex_valid <= r_ifid_valid; r_idex_rw <= w_rw;
            r_idex_mr <= w_mr; r_idex_mw <= w_mw;
            r_idex_br <= w_br; r_idex_isrc <= w_isrc;
            r_idex_aop <= w_aop; r_idex_dst <= w_dst;
            r_idex_rs <= w_rs; r_idex_rt <= w_rt;
            r_idex_pc <= r_ifid_pc; r_idex_imm <= w_imm;
            r_idex_rsv <= w_rsv; r_idex_rtv <= w_rtv;
        end
    end

    // EX/MEM: flushed only when beq resolves in MEM.
    always_ff @(posedge clk) begin
        if (reset || (w_flush && BR_RESOLVE_EX == 0)) begin
            r_exmem_valid <= 1'b0; r_exmem_rw <= 1'b0;
            r_exmem_mr <= 1'b0; r_exmem_mw <= 1'b0;
            r_exmem_take <= 1'b0; r_exmem_dst <= 5'd0;
            r_exmem_pc <= '0; r_exmem_alu <= '0;
            r_exmem_sd <= '0; r_exmem_tgt <= '0;
        end else begin
            r_exmem_valid <= r_idex_valid; r_exmem_rw <= r_idex_rw;
            r_exmem_mr <= r_idex_mr; r_exmem_mw <= r_idex_mw;
            r_exmem_take <= w_ex_take; r_exmem_dst <= r_idex_dst;
            r_exmem_pc <= r_idex_pc; r_exmem_alu <= w_alu;
            r_exmem_sd <= w_fb; r_exmem_tgt <= w_ex_tgt;
        end
    end

    // MEM/WB: pick load data or ALU result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_memwb_valid <= 1'b0; r_memwb_rw <= 1'b0;
            r_memwb_dst <= 5'd0; r_memwb_pc <= '0;
            r_memwb_res <= '0;
        end else begin
            r_memwb_valid <= r_exmem_valid; r_memwb_rw <= r_exmem_rw;
            r_memwb_dst <= r_exmem_dst; r_memwb_pc <= r_exmem_pc;
            r_memwb_res <= r_exmem_mr ? dmem_rdata : r_exmem_alu;
        end
    end

    // Register file; $0 is never written so it always reads zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) r_rf[i] <= '0;
        end else if (w_wb_we) begin
            r_rf[r_memwb_dst] <= r_memwb_res;
        end
    end

    assign imem_addr    = r_pc;
    assign dmem_addr    = r_exmem_alu;
    assign dmem_wdata   = r_exmem_sd;
    assign dmem_we      = r_exmem_valid && r_exmem_mw && !reset;
    assign dmem_re      = r_exmem_valid && r_exmem_mr && !reset;
    assign retire_valid = r_memwb_valid && !reset;
    assign retire_pc    = r_memwb_pc;
    assign stall        = w_stall && !reset;

endmodule

// File: tb/tb_mips_pipe_core_fwd.sv
// tb_mips_pipe_core_fwd: directed programs on a forwarding core and an
// interlock-only core with MEM-resolved branches.
module tb_mips_pipe_core_fwd;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr0, imem_rdata0, imem_addr1, imem_rdata1;
    logic [31:0] dmem_addr0, dmem_wdata0, dmem_rdata0;
    logic [31:0] dmem_addr1, dmem_wdata1, dmem_rdata1;
    logic        dmem_we0, dmem_re0, dmem_we1, dmem_re1;
    logic        retire_valid0, retire_valid1, stall0, stall1;
    logic [31:0] retire_pc0, retire_pc1;

    logic [31:0] imem  [64];
    logic [31:0] dmem0 [64];
    logic [31:0] dmem1 [64];

    logic [31:0] rpc0[$], rpc1[$], sa[$], sd[$];
    int          rcy0[$], rcy1[$];
    int          cyc, stl0, stl1, nld;
    int          ntest, nfail;

    always #5 clk = ~clk;

    mips_pipe_core_fwd #(
        .FWD_EN(1), .PC_RESET(32'h0), .BR_RESOLVE_EX(1)
    ) u_dut (
        .clk(clk), .reset(reset),
        .imem_addr(imem_addr0), .imem_rdata(imem_rdata0),
        .dmem_addr(dmem_addr0), .dmem_wdata(dmem_wdata0),
        .dmem_we(dmem_we0), .dmem_re(dmem_re0),
        .dmem_rdata(dmem_rdata0),
        .retire_valid(retire_valid0), .retire_pc(retire_pc0),
        .stall(stall0)
    );

    mips_pipe_core_fwd #(
        .FWD_EN(0), .PC_RESET(32'h0), .BR_RESOLVE_EX(0)
    ) u_ilk (
        .clk(clk), .reset(reset),
        .imem_addr(imem_addr1), .imem_rdata(imem_rdata1),
        .dmem_addr(dmem_addr1), .dmem_wdata(dmem_wdata1),
        .dmem_we(dmem_we1), .dmem_re(dmem_re1),
        .dmem_rdata(dmem_rdata1),
        .retire_valid(retire_valid1), .retire_pc(retire_pc1),
        .stall(stall1)
    );

    assign imem_rdata0 = imem[imem_addr0[7:2]];
    assign imem_rdata1 = imem[imem_addr1[7:2]];
    assign dmem_rdata0 = dmem0[dmem_addr0[7:2]];
    assign dmem_rdata1 = dmem1[dmem_addr1[7:2]];

    always @(posedge clk) begin
        if (dmem_we0) dmem0[dmem_addr0[7:2]] <= dmem_wdata0;
        if (dmem_we1) dmem1[dmem_addr1[7:2]] <= dmem_wdata1;
    end

    // Log retires, stalls and stores, with cycle 0 = first fetch.
    always @(negedge clk) begin
        if (reset) begin
            cyc = 0;
        end else begin
            if (retire_valid0) begin
                rpc0.push_back(retire_pc0); rcy0.push_back(cyc);
            end
            if (retire_valid1) begin
                rpc1.push_back(retire_pc1); rcy1.push_back(cyc);
            end
            if (stall0) stl0++;
            if (stall1) stl1++;
            if (dmem_re0) nld++;
            if (dmem_we0) begin
                sa.push_back(dmem_addr0); sd.push_back(dmem_wdata0);
            end
            cyc++;
        end
    end

    function automatic logic [31:0] enc_i(
        input logic [5:0] op, input int rt, input int rs, input int imm
    );
        return {op, rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    function automatic logic [31:0] enc_r(
        input logic [5:0] fn, input int rd, input int rs, input int rt
    );
        return {6'b0, rs[4:0], rt[4:0], rd[4:0], 5'b0, fn};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] tgt);
        return {6'b000010, tgt[27:2]};
    endfunction

    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100, F_OR = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    task automatic chk(
        input string tag, input logic [31:0] obs, input logic [31:0] exp
    );
        ntest++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 64; i++) begin
            imem[i] = 32'h0;
            dmem0[i] <= 32'h0;
            dmem1[i] <= 32'h0;
        end
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        rpc0.delete(); rcy0.delete(); rpc1.delete(); rcy1.delete();
        sa.delete(); sd.delete();
        stl0 = 0; stl1 = 0; nld = 0;
        reset = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        ntest = 0; nfail = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we",   {31'b0, dmem_we0}, 32'd0);
        chk("rst_re",   {31'b0, dmem_re0}, 32'd0);
        chk("rst_ret",  {31'b0, retire_valid0}, 32'd0);
        chk("rst_stl",  {31'b0, stall0}, 32'd0);
        chk("rst_pc",   imem_addr0, 32'h0);

        // Dependent addi/addi/add chain.
        hold_reset();
        imem[0] = enc_i(OP_ADDI, 1, 0, 5);
        imem[1] = enc_i(OP_ADDI, 2, 1, 3);
        imem[2] = enc_r(F_ADD, 3, 1, 2);
        imem[5] = enc_i(OP_SW, 3, 0, 16);
        release_reset();
        run(24);
        chk("t1_cy0",   32'(rcy0[0]), 32'd4);
        chk("t1_pc0",   rpc0[0], 32'h0);
        chk("t1_cy1",   32'(rcy0[1]), 32'd5);
        chk("t1_pc1",   rpc0[1], 32'h4);
        chk("t1_cy2",   32'(rcy0[2]), 32'd6);
        chk("t1_pc2",   rpc0[2], 32'h8);
        chk("t1_stall", 32'(stl0), 32'd0);
        chk("t1_r3",    dmem0[4], 32'd13);
        chk("t1i_stl",  32'(stl1), 32'd4);
        chk("t1i_pc2",  rpc1[2], 32'h8);
        chk("t1i_cy2",  32'(rcy1[2]), 32'd10);
        chk("t1i_r3",   dmem1[4], 32'd13);

        // Store, load, load-use.
        hold_reset();
        dmem0[8] <= 32'hDEAD_BEEF;
        imem[0] = enc_i(OP_LW, 1, 0, 32'h20);
        imem[2] = enc_i(OP_SW, 1, 0, 0);
        imem[3] = enc_i(OP_LW, 4, 0, 0);
        imem[4] = enc_r(F_ADD, 5, 4, 4);
        imem[5] = enc_i(OP_SW, 5, 0, 4);
        release_reset();
        run(24);
        chk("t2_nst",   32'(sa.size()), 32'd2);
        chk("t2_sa0",   sa[0], 32'h0);
        chk("t2_sd0",   sd[0], 32'hDEAD_BEEF);
        chk("t2_sa1",   sa[1], 32'h4);
        chk("t2_sd1",   sd[1], 32'hBD5B_7DDE);
        chk("t2_stall", 32'(stl0), 32'd1);
        chk("t2_nld",   32'(nld), 32'd2);
        chk("t2_r5",    dmem0[1], 32'hBD5B_7DDE);

        // Taken beq at 0x10, then j 0x40 at 0x20.
        hold_reset();
        imem[4]  = enc_i(OP_BEQ, 0, 0, 2);
        imem[5]  = enc_i(OP_ADDI, 6, 0, 1);
        imem[6]  = enc_i(OP_ADDI, 7, 0, 1);
        imem[7]  = enc_i(OP_ADDI, 8, 0, 1);
        imem[8]  = enc_j(32'h40);
        imem[9]  = enc_i(OP_ADDI, 9, 0, 1);
        imem[16] = enc_i(OP_SW, 6, 0, 32'h30);
        imem[17] = enc_i(OP_SW, 7, 0, 32'h34);
        imem[18] = enc_i(OP_SW, 8, 0, 32'h38);
        imem[19] = enc_i(OP_SW, 9, 0, 32'h3C);
        for (int i = 12; i < 16; i++) begin
            dmem0[i] <= 32'h5555; dmem1[i] <= 32'h5555;
        end
        release_reset();
        run(30);
        chk("t3_pc4",   rpc0[4], 32'h10);
        chk("t3_pc5",   rpc0[5], 32'h1C);
        chk("t3_gap",   32'(rcy0[5] - rcy0[4]), 32'd3);
        chk("t3_pc6",   rpc0[6], 32'h20);
        chk("t3_pc7",   rpc0[7], 32'h40);
        chk("t3_jgap",  32'(rcy0[7] - rcy0[6]), 32'd2);
        chk("t3_r6",    dmem0[12], 32'd0);
        chk("t3_r7",    dmem0[13], 32'd0);
        chk("t3_r8",    dmem0[14], 32'd1);
        chk("t3_r9",    dmem0[15], 32'd0);
        chk("t3i_pc5",  rpc1[5], 32'h1C);
        chk("t3i_gap",  32'(rcy1[5] - rcy1[4]), 32'd4);
        chk("t3i_r7",   dmem1[13], 32'd0);
        chk("t3i_r8",   dmem1[14], 32'd1);

        // Writes to $0, unknown opcode, ALU ops.
        hold_reset();
        imem[0]  = enc_i(OP_ADDI, 0, 0, 7);
        imem[1]  = enc_i(OP_SW, 0, 0, 32'h40);
        imem[2]  = 32'hFFFF_FFFF;
        imem[3]  = enc_i(OP_SW, 0, 0, 32'h44);
        imem[4]  = enc_i(OP_SW, 31, 0, 32'h48);
        imem[5]  = enc_i(OP_ADDI, 10, 0, -3);
        imem[6]  = enc_i(OP_ADDI, 11, 0, 5);
        imem[7]  = enc_r(F_SUB, 12, 11, 10);
        imem[8]  = enc_r(F_AND, 13, 10, 11);
        imem[9]  = enc_r(F_OR, 14, 10, 11);
        imem[10] = enc_r(F_SLT, 15, 10, 11);
        imem[11] = enc_r(F_SLT, 16, 11, 10);
        for (int i = 0; i < 5; i++)
            imem[12 + i] = enc_i(OP_SW, 12 + i, 0, 32'h60 + 4 * i);
        for (int i = 16; i < 29; i++) dmem0[i] <= 32'h1111;
        release_reset();
        run(28);
        chk("t5_pc1",   rpc0[1], 32'h4);
        chk("t5_pc2",   rpc0[2], 32'h8);
        chk("t5_pc3",   rpc0[3], 32'hC);
        chk("t5_nst",   32'(sa.size()), 32'd8);
        chk("t5_r0a",   dmem0[16], 32'd0);
        chk("t5_r0b",   dmem0[17], 32'd0);
        chk("t5_r31",   dmem0[18], 32'd0);
        chk("t5_sub",   dmem0[24], 32'd8);
        chk("t5_and",   dmem0[25], 32'd5);
        chk("t5_or",    dmem0[26], 32'hFFFF_FFFD);
        chk("t5_slt1",  dmem0[27], 32'd1);
        chk("t5_slt0",  dmem0[28], 32'd0);

        // Reset while a sw sits in EX.
        hold_reset();
        imem[0] = enc_i(OP_ADDI, 1, 0, 32'h55);
        imem[2] = enc_i(OP_SW, 1, 0, 32'h50);
        dmem0[20] <= 32'hAAAA;
        release_reset();
        run(4);
        reset = 1'b1;
        #1;
        chk("t6_we",    {31'b0, dmem_we0}, 32'd0);
        chk("t6_ret",   {31'b0, retire_valid0}, 32'd0);
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
        release_reset();
        run(8);
        chk("t6_first", 32'(rcy0[0]), 32'd4);
        chk("t6_nst",   32'(sa.size()), 32'd0);
        chk("t6_mem",   dmem0[20], 32'hAAAA);

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule
